uart_rx_frame_sampler: RTL and testbench
========================================

// Module: uart_rx_frame_sampler
// PURPOSE
//   UART RX front end: oversamples RX_IN, majority-votes each bit and sequences the
//   frame (start, data, optional parity, stop). Deserializes data LSB-first into P_DATA.
//   Sits directly upstream of the RX parity checker and drives its par_check_en,
//   sampled_bit and P_DATA inputs. Also flags start glitches and stop errors, and
//   pulses frame_done at the end of each frame.
// PARAMETERS
//   Data_size   8   data bits per frame; also the width of P_DATA
// PORTS
//   clk           in   1          system clock; Prescale cycles per UART bit
//   rst           in   1          synchronous, active-high reset
//   RX_IN         in   1          serial line, idles high; already synchronized upstream
//   PAR_EN        in   1          1 = frame carries a parity bit
//   Prescale      in   6          oversampling ratio; 8, 16 or 32
//   P_DATA        out  Data_size  deserialized data bits, LSB first
//   sampled_bit   out  1          majority-voted value of the current bit
//   par_check_en  out  1          1-cycle strobe: parity bit decided, sampled_bit valid
//   strt_glitch   out  1          1-cycle pulse: start bit sampled high, frame aborted
//   stp_err       out  1          1-cycle pulse: stop bit sampled low
//   frame_done    out  1          1-cycle pulse: stop bit finished (good or bad)
// BEHAVIOUR
//   Reset: state=IDLE; edge_cnt=0; bit_cnt=0; P_DATA=0; sampled_bit=1;
//     all pulse outputs are 0. A reset mid-frame aborts the frame with no pulses.
//   Timing
//     - PAR_EN and Prescale are latched on IDLE->START; later changes do not affect
//       the current frame.
//     - Latched Prescale values below 6 are treated as 8.
//     - edge_cnt runs 0..P-1 within each bit and wraps to 0 at the bit boundary.
//     - The IDLE cycle in which RX_IN==0 is seen is edge 0 of the start bit.
//   Sampling
//     - RX_IN is captured at edge_cnt = P/2-1, P/2 and P/2+1.
//     - sampled_bit takes the majority (>=2 of 3) at edge_cnt = P/2+2 and holds
//       until the next bit's update.
//   "End of bit" is edge_cnt==P-1. Pulse outputs are registered: they are high for
//     exactly the one cycle after the end-of-bit edge.
//   FSM
//     IDLE:   RX_IN==0 -> START; edge_cnt=1 next cycle.
//     START:  end of bit: sampled_bit==1 -> strt_glitch pulse, go to IDLE;
//             else -> DATA with bit_cnt=0.
//     DATA:   end of bit: P_DATA[bit_cnt] <= sampled_bit; bit_cnt++.
//             After Data_size bits -> PARITY if PAR_EN, else STOP.
//     PARITY: end of bit: par_check_en pulse, then STOP. sampled_bit still holds the
//             parity value during the strobe, so the checker's par_err is valid
//             one cycle after the strobe.
//     STOP:   end of bit: frame_done pulse; stp_err = ~sampled_bit in the same cycle.
//             -> IDLE.
//   Outputs
//     - P_DATA bits are overwritten only by the next frame's data bits.
//     - A glitched frame leaves P_DATA untouched.
//     - P_DATA is stable while frame_done is high.
//   Back-to-back: a start edge in the first IDLE cycle after STOP is accepted.
//   Simultaneous rst and an end-of-bit event: rst wins; no pulse.
// TESTING
//   1. P=8, PAR_EN=0, frame 0xA5 + stop 1, start seen at t0
//      -> P_DATA=0xA5; frame_done=1 only at t0+80; stp_err=0; par_check_en never 1.
//   2. P=8, PAR_EN=1, data 0x3C, parity bit 0, stop 1
//      -> par_check_en=1 only at t0+80 with sampled_bit=0; frame_done at t0+88.
//   3. P=16, RX_IN low for 3 cycles then high
//      -> strt_glitch=1 at t0+16; no frame_done; next frame received normally.
//   4. P=16, data 0x55 with one flipped sample at P/2 in every bit
//      -> P_DATA=0x55, no errors.
//   5. P=8, 0xFF with stop bit 0 -> frame_done=1 and stp_err=1 in the same cycle.
//   6. rst=1 for 1 cycle during the DATA bit 4 of a 0x81 frame
//      -> outputs equal reset values next cycle; no frame_done;
//      a following frame 0x81 gives P_DATA=0x81.

Source files
------------

// File: rtl/uart_rx_frame_sampler.sv
// UART RX front end: oversamples the serial line, majority-votes each bit and sequences
// start/data/parity/stop, deserializing data LSB first into P_DATA.
module uart_rx_frame_sampler #(
  parameter int unsigned Data_size = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 RX_IN,
  input  logic                 PAR_EN,
  input  logic [5:0]           Prescale,
  output logic [Data_size-1:0] P_DATA,
  output logic                 sampled_bit,
  output logic                 par_check_en,
  output logic                 strt_glitch,
  output logic                 stp_err,
  output logic                 frame_done
);

  localparam int unsigned BitW = (Data_size > 1) ? $clog2(Data_size) : 1;
  localparam logic [BitW-1:0] LastBit = BitW'(Data_size - 1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e          state_q;
  logic [5:0]      edge_cnt_q;
  logic [5:0]      presc_q;
  logic [BitW-1:0] bit_cnt_q;
  logic            par_en_q;
  logic [2:0]      smp_q;

  logic [5:0] half;
  logic [5:0] smp_lo;
  logic [5:0] smp_hi;
  logic [5:0] vote_edge;
  logic [5:0] last_edge;
  logic       end_of_bit;
  logic       vote;

  always_comb begin
    half       = presc_q >> 1;
    smp_lo     = half - 6'd1;
    smp_hi     = half + 6'd1;
    vote_edge  = half + 6'd2;
    last_edge  = presc_q - 6'd1;
    end_of_bit = (edge_cnt_q == last_edge);
    vote       = (smp_q[0] & smp_q[1]) | (smp_q[0] & smp_q[2]) | (smp_q[1] & smp_q[2]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      edge_cnt_q   <= 6'd0;
      bit_cnt_q    <= '0;
      presc_q      <= 6'd8;
      par_en_q     <= 1'b0;
      smp_q        <= 3'b111;
      P_DATA       <= '0;
      sampled_bit  <= 1'b1;
      par_check_en <= 1'b0;
      strt_glitch  <= 1'b0;
      stp_err      <= 1'b0;
      frame_done   <= 1'b0;
    end else begin
      par_check_en <= 1'b0;
      strt_glitch  <= 1'b0;
      stp_err      <= 1'b0;
      frame_done   <= 1'b0;

      // Three samples around mid-bit, voted one edge after the last capture.
      if (state_q != StIdle) begin
        if (edge_cnt_q == smp_lo) smp_q[0] <= RX_IN;
        if (edge_cnt_q == half)   smp_q[1] <= RX_IN;
        if (edge_cnt_q == smp_hi) smp_q[2] <= RX_IN;
        if (edge_cnt_q == vote_edge) sampled_bit <= vote;
        edge_cnt_q <= end_of_bit ? 6'd0 : edge_cnt_q + 6'd1;
      end

      unique case (state_q)
        StIdle: begin
          edge_cnt_q <= 6'd0;
          if (!RX_IN) begin
            // This cycle is edge 0 of the start bit.
            state_q    <= StStart;
            edge_cnt_q <= 6'd1;
            presc_q    <= (Prescale < 6'd6) ? 6'd8 : Prescale;
            par_en_q   <= PAR_EN;
          end
        end
        StStart: begin
          if (end_of_bit) begin
            if (sampled_bit) begin
              strt_glitch <= 1'b1;
              state_q     <= StIdle;
            end else begin
              bit_cnt_q <= '0;
              state_q   <= StData;
            end
          end
        end
        StData: begin
          if (end_of_bit) begin
            P_DATA[bit_cnt_q] <= sampled_bit;
            bit_cnt_q         <= bit_cnt_q + BitW'(1);
            if (bit_cnt_q == LastBit) begin
              state_q <= par_en_q ? StParity : StStop;
            end
          end
        end
        StParity: begin
          if (end_of_bit) begin
            par_check_en <= 1'b1;
            state_q      <= StStop;
          end
        end
        StStop: begin
          if (end_of_bit) begin
            frame_done <= 1'b1;
            stp_err    <= ~sampled_bit;
            state_q    <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Self-checking bench for uart_rx_frame_sampler: table of frames driven serially, with
// expected pulses queued at the start edge and matched when the DUT pulses.
module tb_uart_rx_frame_sampler;

  localparam int DW      = 8;
  localparam int KPar    = 0;
  localparam int KDone   = 1;
  localparam int KGlitch = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          RX_IN;
  logic          PAR_EN;
  logic [5:0]    Prescale;
  logic [DW-1:0] P_DATA;
  logic          sampled_bit;
  logic          par_check_en;
  logic          strt_glitch;
  logic          stp_err;
  logic          frame_done;

  typedef struct {
    int         kind;
    int         cyc;
    logic [7:0] pdata;
    logic       bitv;
  } exp_t;

  typedef struct {
    logic [7:0] data;
    logic       par_en;
    logic       par_bit;
    logic       stop_bit;
    logic [5:0] presc;
    logic       flip;
    int         glitch;
    int         gap;
    logic [7:0] exp_pdata;
    logic       exp_stp_err;
  } vec_t;

  exp_t sb_q[$];
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  uart_rx_frame_sampler #(.Data_size(DW)) dut (
    .clk          (clk),
    .rst          (rst),
    .RX_IN        (RX_IN),
    .PAR_EN       (PAR_EN),
    .Prescale     (Prescale),
    .P_DATA       (P_DATA),
    .sampled_bit  (sampled_bit),
    .par_check_en (par_check_en),
    .strt_glitch  (strt_glitch),
    .stp_err      (stp_err),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected finish", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_p_data"}, 32'(P_DATA), 32'h0);
    check({tag, "_sampled_bit"}, 32'(sampled_bit), 32'h1);
    check({tag, "_pulses"}, 32'({stp_err, frame_done, par_check_en, strt_glitch}), 32'h0);
  endtask

  // Scoreboard consumer: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    int   kind;
    exp_t e;
    if (rst === 1'b0) begin
      if (frame_done || par_check_en || strt_glitch) begin
        kind = frame_done ? KDone : (par_check_en ? KPar : KGlitch);
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pulse: got kind %0d at cycle %0d, expected no pulse",
                   kind, cyc);
        end else begin
          e = sb_q.pop_front();
          check("pulse_kind", 32'(kind), 32'(e.kind));
          check("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (e.kind == KPar) begin
            check("parity_sampled_bit", 32'(sampled_bit), 32'(e.bitv));
          end else if (e.kind == KDone) begin
            check("frame_p_data", 32'(P_DATA), 32'(e.pdata));
            check("frame_stp_err", 32'(stp_err), 32'(e.bitv));
          end else begin
            check("glitch_p_data", 32'(P_DATA), 32'(e.pdata));
          end
        end
      end else if (stp_err) begin
        tests++;
        fails++;
        $display("FAIL stray_stp_err: got 1 at cycle %0d, expected 0 without frame_done", cyc);
      end
    end
  end

  // Drives one frame; max_cyc >= 0 truncates it and queues no expectations.
  task automatic send_frame(input vec_t v, input int max_cyc);
    int   p;
    int   nb;
    int   t0;
    int   k;
    logic val;
    p  = (v.presc < 6'd6) ? 8 : int'(v.presc);
    nb = (v.glitch > 0) ? 1 : 2 + DW + int'(v.par_en);
    PAR_EN   = v.par_en;
    Prescale = v.presc;
    repeat (v.gap) begin
      @(negedge clk);
      RX_IN = 1'b1;
    end
    @(negedge clk);
    t0 = cyc;
    if (max_cyc < 0) begin
      if (v.glitch > 0) begin
        sb_q.push_back('{KGlitch, t0 + p, v.exp_pdata, 1'b1});
      end else begin
        if (v.par_en) sb_q.push_back('{KPar, t0 + (2 + DW) * p, 8'h00, v.par_bit});
        sb_q.push_back('{KDone, t0 + nb * p, v.exp_pdata, v.exp_stp_err});
      end
    end
    k = 0;
    for (int b = 0; b < nb; b++) begin
      for (int e = 0; e < p; e++) begin
        if (max_cyc >= 0 && k >= max_cyc) return;
        if (k > 0) @(negedge clk);
        if (b == 0)           val = (v.glitch > 0) ? (e >= v.glitch) : 1'b0;
        else if (b <= DW)     val = v.data[b-1];
        else if (b == nb - 1) val = v.stop_bit;
        else                  val = v.par_bit;
        if (v.flip && e == p / 2) val = ~val;
        RX_IN = val;
        // Mid-frame changes to the config inputs must be ignored.
        if (k == 1) begin
          PAR_EN   = ~v.par_en;
          Prescale = (p == 8) ? 6'd32 : 6'd8;
        end
        k++;
      end
    end
  endtask

  vec_t vecs[10];
  vec_t hv;

  initial begin
    //          data   pe    pb    stop  presc  flip  gl gap exp    se
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b1, 6'd8,  1'b0, 0, 4, 8'hA5, 1'b0};
    vecs[1] = '{8'h3C, 1'b1, 1'b0, 1'b1, 6'd8,  1'b0, 0, 3, 8'h3C, 1'b0};
    vecs[2] = '{8'h00, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0, 3, 5, 8'h3C, 1'b0};
    vecs[3] = '{8'h5A, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0, 0, 2, 8'h5A, 1'b0};
    vecs[4] = '{8'h55, 1'b0, 1'b0, 1'b1, 6'd16, 1'b1, 0, 3, 8'h55, 1'b0};
    vecs[5] = '{8'h00, 1'b0, 1'b0, 1'b1, 6'd16, 1'b0, 0, 0, 8'h00, 1'b0};
    vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 6'd8,  1'b0, 0, 3, 8'hFF, 1'b1};
    vecs[7] = '{8'h96, 1'b1, 1'b1, 1'b1, 6'd8,  1'b0, 0, 0, 8'h96, 1'b0};
    vecs[8] = '{8'hC3, 1'b0, 1'b0, 1'b1, 6'd32, 1'b1, 0, 2, 8'hC3, 1'b0};
    vecs[9] = '{8'h0F, 1'b1, 1'b1, 1'b1, 6'd4,  1'b0, 0, 3, 8'h0F, 1'b0};

    rst      = 1'b1;
    RX_IN    = 1'b1;
    PAR_EN   = 1'b0;
    Prescale = 6'd8;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    foreach (vecs[i]) send_frame(vecs[i], -1);

    // Reset coinciding with the stop bit's last edge: no frame_done.
    hv = '{8'h12, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 0, 3, 8'h00, 1'b0};
    send_frame(hv, 79);
    @(negedge clk);
    RX_IN = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_at_stop_end");

    // Reset during data bit 4 of 0x81, then a clean 0x81 frame.
    hv = '{8'h81, 1'b0, 1'b0, 1'b1, 6'd8, 1'b0, 0, 3, 8'h81, 1'b0};
    send_frame(hv, 43);
    @(negedge clk);
    RX_IN = 1'b1;
    rst   = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_mid_data");
    repeat (100) @(negedge clk);
    send_frame(hv, -1);

    @(negedge clk);
    RX_IN = 1'b1;
    repeat (60) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
